// File: rtl/fifo_rptr_aempty_if.sv
// Read-side signal bundle between the read-pointer block and its consumer.
// The master drives read requests and the synchronised write pointer.
interface fifo_rptr_aempty_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  Rinc;
    logic                  Rflush;
    logic [ADDR_WIDTH:0]   R2q_wptr;
    logic [ADDR_WIDTH-1:0] Raddr;
    logic [ADDR_WIDTH:0]   Rptr;
    logic                  Rempty;
    logic                  Raempty;
    logic [ADDR_WIDTH:0]   Rlevel;
    logic                  Rpop;
    logic                  Runderflow;

    modport master (
        output Rinc, Rflush, R2q_wptr,
        input  Raddr, Rptr, Rempty, Raempty, Rlevel, Rpop, Runderflow
    );

    modport slave (
        input  Rinc, Rflush, R2q_wptr,
        output Raddr, Rptr, Rempty, Raempty, Rlevel, Rpop, Runderflow
    );
endinterface

// File: rtl/fifo_rptr_aempty.sv
// Read-domain pointer of an async FIFO: Gray read pointer, empty/almost-empty
// flags, fill level, flush and sticky underflow, all registered on Rclk.
module fifo_rptr_aempty #(
    parameter int ADDR_WIDTH    = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input logic               Rclk,
    input logic               Rrst,
    fifo_rptr_aempty_if.slave rif
);
    localparam int PW = ADDR_WIDTH + 1;

    if (ADDR_WIDTH < 2 || ADDR_WIDTH > 12) begin : g_bad_addr_width
        $error("fifo_rptr_aempty: ADDR_WIDTH out of range 2..12");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > (1 << ADDR_WIDTH) - 1) begin : g_bad_thresh
        $error("fifo_rptr_aempty: AEMPTY_THRESH out of range");
    end

    localparam logic [PW-1:0] THRESH = PW'(AEMPTY_THRESH);

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          rempty_q, rempty_d;
    logic          raempty_q, raempty_d;
    logic          runderflow_q, runderflow_d;
    logic [PW-1:0] wbin;
    logic          rpop;

    always_comb begin
        wbin = '0;
        // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(rif.R2q_wptr >> i);
        end

        rpop = rif.Rinc & ~rempty_q & ~rif.Rflush;

        rbin_d = rbin_q;
        if (rif.Rflush) begin
            rbin_d = wbin;
        end else if (rpop) begin
            rbin_d = rbin_q + PW'(1);
        end

        rptr_d       = (rbin_d >> 1) ^ rbin_d;
        rlevel_d     = wbin - rbin_d;
        rempty_d     = (rptr_d == rif.R2q_wptr);
        raempty_d    = (rlevel_d <= THRESH);
        runderflow_d = runderflow_q | (rif.Rinc & rempty_q & ~rif.Rflush);
    end

    always_ff @(posedge Rclk) begin
        if (Rrst) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rlevel_q     <= '0;
            rempty_q     <= 1'b1;
            raempty_q    <= 1'b1;
            runderflow_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            rlevel_q     <= rlevel_d;
            rempty_q     <= rempty_d;
            raempty_q    <= raempty_d;
            runderflow_q <= runderflow_d;
        end
    end

    assign rif.Raddr      = rbin_q[ADDR_WIDTH-1:0];
    assign rif.Rptr       = rptr_q;
    assign rif.Rempty     = rempty_q;
    assign rif.Raempty    = raempty_q;
    assign rif.Rlevel     = rlevel_q;
    assign rif.Rpop       = rpop;
    assign rif.Runderflow = runderflow_q;
endmodule

// File: tb/tb_fifo_rptr_aempty.sv
// Randomized self-checking bench for fifo_rptr_aempty (ADDR_WIDTH=4, AEMPTY_THRESH=2)
// against a pointer-count model of the read side.
module tb_fifo_rptr_aempty;
    logic Rclk = 1'b0;
    logic Rrst = 1'b0;
    always #5 Rclk = ~Rclk;

    fifo_rptr_aempty_if #(.ADDR_WIDTH(4)) rif ();
    fifo_rptr_aempty #(.ADDR_WIDTH(4), .AEMPTY_THRESH(2)) dut (
        .Rclk(Rclk), .Rrst(Rrst), .rif(rif)
    );

    int npass = 0;
    int ntot  = 0;

    // Model: binary write/read counts modulo 32 plus registered flag state.
    logic [4:0] mw = '0, mr = '0, m_level = '0;
    bit         m_empty = 1'b1, m_aempty = 1'b1, m_uf = 1'b0;
    logic       pop_obs;
    bit         pop_exp;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [16:0] exp_vec();
        return {gray(mr), mr[3:0], m_empty, m_aempty, m_level, m_uf};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {rif.Rptr, rif.Raddr, rif.Rempty, rif.Raempty, rif.Rlevel, rif.Runderflow};
    endfunction

    task automatic step(input bit inc, input bit flush, input bit rst, input logic [4:0] wb);
        rif.Rinc     = inc;
        rif.Rflush   = flush;
        Rrst         = rst;
        rif.R2q_wptr = gray(wb);
        #1;
        pop_obs = rif.Rpop;
        pop_exp = inc && !m_empty && !flush;
        @(posedge Rclk);
        mw = wb;
        if (rst) begin
            mr = '0; m_uf = 1'b0; m_level = '0; m_empty = 1'b1; m_aempty = 1'b1;
        end else begin
            if (inc && m_empty && !flush) m_uf = 1'b1;
            if (flush) mr = mw;
            else if (pop_exp) mr = mr + 5'd1;
            m_level  = mw - mr;
            m_empty  = (m_level == 0);
            m_aempty = (m_level <= 5'd2);
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b1, 5'd0);
        ntot++;
        if (dut_vec() !== exp_vec()) begin
            $display("FAIL reset_state act=%h exp=%h", dut_vec(), exp_vec());
        end else npass++;
        ntot++;
        if (rif.Rptr !== 5'b00000 || rif.Rempty !== 1'b1 || rif.Runderflow !== 1'b0) begin
            $display("FAIL reset_consts rptr=%b empty=%b uf=%b", rif.Rptr, rif.Rempty, rif.Runderflow);
        end else npass++;
        // Rpop must be low in the first cycle after reset even with Rinc high
        step(1'b1, 1'b0, 1'b0, 5'd0);
        ntot++;
        if (pop_obs !== 1'b0) $display("FAIL reset_pop act=%b exp=0", pop_obs);
        else npass++;
        step(1'b0, 1'b0, 1'b1, 5'd0);
    endtask

    task automatic test_fill_drain();
        step(1'b0, 1'b0, 1'b0, 5'd5);
        ntot++;
        if (rif.Rlevel !== 5'd5 || rif.Rempty !== 1'b0 || rif.Raempty !== 1'b0) begin
            $display("FAIL fill_level lvl=%0d empty=%b aempty=%b exp 5/0/0", rif.Rlevel, rif.Rempty, rif.Raempty);
        end else npass++;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 5'd5);
            ntot++;
            if (pop_obs !== pop_exp || dut_vec() !== exp_vec()) begin
                $display("FAIL drain_%0d pop=%b/%b act=%h exp=%h", i, pop_obs, pop_exp, dut_vec(), exp_vec());
            end else npass++;
        end
        ntot++;
        if (rif.Rptr !== 5'b00111 || rif.Rempty !== 1'b1 || rif.Raempty !== 1'b1) begin
            $display("FAIL drain_end rptr=%b empty=%b aempty=%b", rif.Rptr, rif.Rempty, rif.Raempty);
        end else npass++;
    endtask

    task automatic test_wrap();
        int reads = 0;
        int wraps = 0;
        logic [3:0] prev_addr;
        logic [4:0] wb;
        step(1'b0, 1'b0, 1'b1, 5'd0);
        prev_addr = rif.Raddr;
        for (int cyc = 0; cyc < 400 && reads < 34; cyc++) begin
            wb = mw;
            if (5'(mw - mr) < 5'd16 && ($urandom % 3 != 0)) wb = mw + 5'd1;
            step(($urandom % 4) != 0, 1'b0, 1'b0, wb);
            if (pop_exp) reads++;
            ntot++;
            if (pop_obs !== pop_exp || dut_vec() !== exp_vec()) begin
                $display("FAIL wrap_cyc%0d pop=%b/%b act=%h exp=%h", cyc, pop_obs, pop_exp, dut_vec(), exp_vec());
            end else npass++;
            if (prev_addr == 4'd15 && rif.Raddr == 4'd0) wraps++;
            prev_addr = rif.Raddr;
            if (pop_exp && reads == 16) begin
                ntot++;
                if (rif.Rptr !== 5'b11000) $display("FAIL wrap_rptr16 act=%b exp=11000", rif.Rptr);
                else npass++;
            end
            if (pop_exp && reads == 32) begin
                ntot++;
                if (rif.Rptr !== 5'b00000) $display("FAIL wrap_rptr32 act=%b exp=00000", rif.Rptr);
                else npass++;
            end
        end
        ntot++;
        if (reads != 34 || wraps != 2) $display("FAIL wrap_count reads=%0d wraps=%0d exp 34/2", reads, wraps);
        else npass++;
    endtask

    task automatic test_underflow();
        logic [4:0] ptr0;
        step(1'b0, 1'b0, 1'b0, mr);
        ptr0 = rif.Rptr;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, mr);
            ntot++;
            if (pop_obs !== 1'b0 || rif.Rptr !== ptr0 || rif.Runderflow !== 1'b1) begin
                $display("FAIL underflow_%0d pop=%b rptr=%b/%b uf=%b", i, pop_obs, rif.Rptr, ptr0, rif.Runderflow);
            end else npass++;
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, mw + 5'd1);
        ntot++;
        if (dut_vec() !== exp_vec() || rif.Runderflow !== 1'b1) begin
            $display("FAIL underflow_hold act=%h exp=%h", dut_vec(), exp_vec());
        end else npass++;
    endtask

    task automatic test_flush();
        logic uf0;
        step(1'b0, 1'b0, 1'b0, mr + 5'd9);
        ntot++;
        if (rif.Rlevel !== 5'd9) $display("FAIL flush_pre level act=%0d exp=9", rif.Rlevel);
        else npass++;
        uf0 = rif.Runderflow;
        step(1'b1, 1'b1, 1'b0, mw);
        ntot++;
        if (pop_obs !== 1'b0) $display("FAIL flush_pop act=%b exp=0", pop_obs);
        else npass++;
        ntot++;
        if (rif.Rptr !== gray(mw) || rif.Rempty !== 1'b1 || rif.Raempty !== 1'b1 ||
            rif.Rlevel !== 5'd0 || rif.Runderflow !== uf0) begin
            $display("FAIL flush_state act=%h exp=%h", dut_vec(), exp_vec());
        end else npass++;
    endtask

    task automatic test_midreset();
        step(1'b0, 1'b0, 1'b0, mr + 5'd7);
        ntot++;
        if (rif.Rlevel !== 5'd7) $display("FAIL midrst_pre level act=%0d exp=7", rif.Rlevel);
        else npass++;
        step(1'b1, 1'b0, 1'b1, mw);
        ntot++;
        if (dut_vec() !== {5'b0, 4'b0, 1'b1, 1'b1, 5'd0, 1'b0}) begin
            $display("FAIL midrst_state act=%h exp=%h", dut_vec(), {5'b0, 4'b0, 1'b1, 1'b1, 5'd0, 1'b0});
        end else npass++;
    endtask

    task automatic test_random();
        logic [4:0] wb;
        bit rst;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst = ($urandom % 60) == 0;
            wb  = mw;
            if (rst) wb = 5'd0;
            else if (5'(mw - mr) < 5'd16 && ($urandom % 3 == 0)) wb = mw + 5'd1;
            step($urandom % 2 == 1, ($urandom % 40) == 0, rst, wb);
            ntot++;
            if (pop_obs !== pop_exp || dut_vec() !== exp_vec()) begin
                $display("FAIL random_cyc%0d pop=%b/%b act=%h exp=%h", cyc, pop_obs, pop_exp, dut_vec(), exp_vec());
            end else npass++;
        end
    endtask

    initial begin
        rif.Rinc = 1'b0; rif.Rflush = 1'b0; rif.R2q_wptr = '0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_underflow();
        test_flush();
        test_midreset();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
